// File: rtl/rr_arb_pkg.sv
// Shared types, sizes and the rotating-priority search for the round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {IDLE, GRANT} state_t;

  // Returns {found, idx}: first set bit of req scanning last+1, last+2, ... last (mod NUM_REQ).
  function automatic logic [IDX_W:0] next_winner(input logic [NUM_REQ-1:0] req,
                                                  input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] cand;
    logic             found;
    next_winner = '0;
    found       = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = last + IDX_W'(off);
      if (!found && req[cand]) begin
        found       = 1'b1;
        next_winner = {1'b1, cand};
      end
    end
  endfunction

endpackage

// File: rtl/rr_onehot_dec.sv
// 2-to-4 enable decoder turning a granted index into a one-hot grant vector.
module rr_onehot_dec
  import rr_arb_pkg::*;
(
  input  logic               en,
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Four-requester round-robin arbiter with release detection and a hold-time limit.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [IDX_W-1:0]    gnt_idx,
  output logic                gnt_valid
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     last, last_nxt, idx_nxt;
  logic                 valid_nxt;
  logic [CNT_W-1:0]     hold_cnt, cnt_nxt;
  logic [NUM_REQ-1:0]   others, gnt_nxt;
  logic [IDX_W:0]       win_all, win_oth;
  logic                 timeout;

  always_comb begin
    others    = req & ~(NUM_REQ'(1) << gnt_idx);
    win_all   = next_winner(req, last);
    win_oth   = next_winner(others, last);
    timeout   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    state_nxt = state;
    last_nxt  = last;
    idx_nxt   = gnt_idx;
    valid_nxt = gnt_valid;
    cnt_nxt   = hold_cnt;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (en && win_all[IDX_W]) begin
          state_nxt = GRANT;
          idx_nxt   = win_all[IDX_W-1:0];
          last_nxt  = win_all[IDX_W-1:0];
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!en) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end else if (!req[gnt_idx] || timeout) begin
          // Release and timeout share the same hand-off: the next winner among the others.
          cnt_nxt = '0;
          if (win_oth[IDX_W]) begin
            idx_nxt  = win_oth[IDX_W-1:0];
            last_nxt = win_oth[IDX_W-1:0];
          end else if (!req[gnt_idx]) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  rr_onehot_dec u_dec (
    .en  (valid_nxt),
    .idx (idx_nxt),
    .y   (gnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= '1;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      hold_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random traffic against an owner/held-cycles model.
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] req;
  logic [3:0] gnt8, gnt0;
  logic [1:0] idx8, idx0;
  logic       v8, v0;

  int n_total = 0;
  int n_pass  = 0;

  // Model state per instance: 0 -> MAX_HOLD=8, 1 -> MAX_HOLD=0.
  int m_owner[2];
  int m_held[2];
  int m_last[2];
  int hold_lim[2] = '{8, 0};

  always #5 clk = ~clk;

  rr_grant_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(v8)
  );

  rr_grant_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(v0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int pick(input logic [3:0] mask, input int last);
    for (int off = 1; off <= 4; off++)
      if (mask[(last + off) % 4]) return (last + off) % 4;
    return -1;
  endfunction

  task automatic model_step(input int k);
    logic [3:0] oth;
    int w;
    if (rst) begin
      m_owner[k] = -1; m_held[k] = 0; m_last[k] = 3;
    end else if (!en) begin
      m_owner[k] = -1;
    end else if (m_owner[k] < 0) begin
      w = pick(req, m_last[k]);
      if (w >= 0) begin m_owner[k] = w; m_last[k] = w; m_held[k] = 1; end
    end else begin
      oth = req;
      oth[m_owner[k]] = 1'b0;
      w = pick(oth, m_last[k]);
      if (!req[m_owner[k]]) begin
        m_owner[k] = w;
        if (w >= 0) begin m_last[k] = w; m_held[k] = 1; end
      end else if (hold_lim[k] != 0 && m_held[k] >= hold_lim[k]) begin
        m_held[k] = 1;
        if (w >= 0) begin m_owner[k] = w; m_last[k] = w; end
      end else begin
        m_held[k]++;
      end
    end
  endtask

  task automatic compare(input int k, input logic [3:0] g, input logic [1:0] i, input logic v);
    string      s;
    logic [3:0] eg;
    s  = (k == 0) ? "h8" : "h0";
    eg = (m_owner[k] < 0) ? 4'b0000 : 4'(1 << m_owner[k]);
    check({s, ".gnt"}, 32'(g), 32'(eg));
    check({s, ".valid"}, 32'(v), 32'(m_owner[k] >= 0));
    if (m_owner[k] >= 0) check({s, ".idx"}, 32'(i), 32'(m_owner[k]));
    check({s, ".onehot"}, 32'($countones(g) <= 1), 32'd1);
    check({s, ".inv"}, 32'(g), v ? 32'(1 << i) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare(0, gnt8, idx8, v8);
    compare(1, gnt0, idx0, v0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    for (int k = 0; k < 2; k++) begin m_owner[k] = -1; m_held[k] = 0; m_last[k] = 3; end
    tick();
    check("rst.idx", 32'(idx8), 32'd0);
    rst = 1'b0;

    // Full rotation with all four requesting.
    en = 1'b1; req = 4'b1111;
    repeat (40) tick();

    // Release hand-off without an idle bubble.
    do_reset();
    req = 4'b0100;
    repeat (3) tick();
    req = 4'b0001;
    tick();
    check("handoff.gnt", 32'(gnt8), 32'b0001);
    repeat (2) tick();

    // Lone requester keeps the grant across hold-counter wraps.
    req = 4'b1000;
    repeat (20) tick();

    // Enable gating.
    do_reset();
    en = 1'b0; req = 4'b1111;
    repeat (3) tick();
    en = 1'b1;
    tick();
    check("en.gnt", 32'(gnt8), 32'b0001);
    en = 1'b0;
    tick();
    en = 1'b1;

    // Reset mid-grant, then priority restarts from requester 0.
    do_reset();
    req = 4'b0100;
    repeat (2) tick();
    do_reset();
    check("rst2.idx", 32'(idx8), 32'd0);
    req = 4'b0110;
    tick();
    check("rst2.gnt", 32'(gnt8), 32'b0010);

    // Unlimited hold on the MAX_HOLD=0 instance.
    do_reset();
    req = 4'b0011;
    repeat (50) tick();
    check("nohold.gnt", 32'(gnt0), 32'b0001);
    req = 4'b0010;
    tick();
    check("nohold.rel", 32'(gnt0), 32'b0010);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
